ocs_slot_scheduler: RTL and testbench

- Slot timing master inside the OCS controller.
- Waits until every ToR control link is stable, then broadcasts a START command.
- After START it cycles forever through: data slot -> OCS reconfiguration delay -> SYNC broadcast.
- Drives the slot_id that selects the OCS0/OCS1 crossbar permutation.
- Per-channel command valid/ready handshakes feed the per-channel control-frame generators.

---
 rtl/ocs_slot_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_ocs_slot_scheduler.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ocs_slot_scheduler.sv
// OCS slot timing master: waits for stable ToR links, broadcasts START, then loops slot -> reconfig -> SYNC.
// Optional macro OCS_SCHED_CMD_TIMEOUT_EN aborts a command that is not accepted within 4095 cycles.
module ocs_slot_scheduler #(
    parameter int unsigned P_CHANNEL_NUM  = 8,
    parameter logic [31:0] P_LINK_STABLE  = 32'd1000,
    parameter logic [31:0] P_SLOT_LEN     = 32'h0000_04E2,
    parameter logic [31:0] P_CONFIG_DELAY = 32'h0000_007D,
    parameter int unsigned P_SLOT_ID_W    = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [P_CHANNEL_NUM-1:0] i_channel_up,
    output logic [P_CHANNEL_NUM-1:0] o_cmd_valid,
    input  logic [P_CHANNEL_NUM-1:0] i_cmd_ready,
    output logic [1:0]               o_cmd_type,
    output logic [P_SLOT_ID_W-1:0]   o_cmd_slot_id,
    output logic [P_SLOT_ID_W-1:0]   o_slot_id,
    output logic                     o_slot_active,
    output logic                     o_ocs_cfg,
    output logic [15:0]              o_slot_cnt,
    output logic                     o_link_err
);

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_START = 2'b01;
    localparam logic [1:0] CMD_SYNC  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_START,
        ST_SLOT,
        ST_CFG,
        ST_CMD_SYNC
    } state_t;

    state_t                   state, state_next;
    logic [31:0]              stable_cnt, stable_next;
    logic [31:0]              phase_cnt, phase_next;
    logic [P_CHANNEL_NUM-1:0] valid_next;
    logic [1:0]               type_next;
    logic [P_SLOT_ID_W-1:0]   cslot_next;
    logic [P_SLOT_ID_W-1:0]   slot_id_next;
    logic                     active_next;
    logic                     cfg_next;
    logic [15:0]              slot_cnt_next;
    logic                     err_next;
    logic                     all_up;
`ifdef OCS_SCHED_CMD_TIMEOUT_EN
    logic [15:0]              tmo_cnt, tmo_next;
`endif

    assign all_up = &i_channel_up;

    always_comb begin
        state_next    = state;
        stable_next   = stable_cnt;
        phase_next    = phase_cnt;
        valid_next    = o_cmd_valid;
        type_next     = o_cmd_type;
        cslot_next    = o_cmd_slot_id;
        slot_id_next  = o_slot_id;
        active_next   = o_slot_active;
        cfg_next      = o_ocs_cfg;
        slot_cnt_next = o_slot_cnt;
        err_next      = 1'b0;
`ifdef OCS_SCHED_CMD_TIMEOUT_EN
        tmo_next      = tmo_cnt;
`endif
        // Link loss outranks every other transition, including a pending ready.
        if (state != ST_IDLE && !all_up) begin
            state_next   = ST_IDLE;
            err_next     = 1'b1;
            valid_next   = '0;
            type_next    = CMD_NONE;
            cslot_next   = '0;
            slot_id_next = '0;
            active_next  = 1'b0;
            cfg_next     = 1'b0;
            stable_next  = '0;
            phase_next   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!all_up) begin
                        stable_next = '0;
                    end else if (stable_cnt == P_LINK_STABLE - 32'd1) begin
                        state_next  = ST_CMD_START;
                        stable_next = '0;
                        valid_next  = '1;
                        type_next   = CMD_START;
                        cslot_next  = '0;
`ifdef OCS_SCHED_CMD_TIMEOUT_EN
                        tmo_next    = '0;
`endif
                    end else begin
                        stable_next = stable_cnt + 32'd1;
                    end
                end
                ST_CMD_START, ST_CMD_SYNC: begin
                    if (o_cmd_valid == '0) begin
                        state_next  = ST_SLOT;
                        active_next = 1'b1;
                        phase_next  = '0;
                        type_next   = CMD_NONE;
`ifdef OCS_SCHED_CMD_TIMEOUT_EN
                    end else if (tmo_cnt == 16'd4095) begin
                        state_next   = ST_IDLE;
                        err_next     = 1'b1;
                        valid_next   = '0;
                        type_next    = CMD_NONE;
                        cslot_next   = '0;
                        slot_id_next = '0;
                        stable_next  = '0;
`endif
                    end else begin
                        valid_next = o_cmd_valid & ~i_cmd_ready;
`ifdef OCS_SCHED_CMD_TIMEOUT_EN
                        tmo_next   = tmo_cnt + 16'd1;
`endif
                    end
                end
                ST_SLOT: begin
                    if (phase_cnt == P_SLOT_LEN - 32'd1) begin
                        state_next    = ST_CFG;
                        active_next   = 1'b0;
                        cfg_next      = 1'b1;
                        phase_next    = '0;
                        slot_id_next  = o_slot_id + P_SLOT_ID_W'(1);
                        slot_cnt_next = o_slot_cnt + 16'd1;
                    end else begin
                        phase_next = phase_cnt + 32'd1;
                    end
                end
                ST_CFG: begin
                    // The OCS already switched to the new slot_id, so SYNC carries it.
                    if (phase_cnt == P_CONFIG_DELAY - 32'd1) begin
                        state_next = ST_CMD_SYNC;
                        cfg_next   = 1'b0;
                        phase_next = '0;
                        valid_next = '1;
                        type_next  = CMD_SYNC;
                        cslot_next = o_slot_id;
`ifdef OCS_SCHED_CMD_TIMEOUT_EN
                        tmo_next   = '0;
`endif
                    end else begin
                        phase_next = phase_cnt + 32'd1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state         <= ST_IDLE;
            stable_cnt    <= '0;
            phase_cnt     <= '0;
            o_cmd_valid   <= '0;
            o_cmd_type    <= CMD_NONE;
            o_cmd_slot_id <= '0;
            o_slot_id     <= '0;
            o_slot_active <= 1'b0;
            o_ocs_cfg     <= 1'b0;
            o_slot_cnt    <= '0;
            o_link_err    <= 1'b0;
`ifdef OCS_SCHED_CMD_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
        end else begin
            state         <= state_next;
            stable_cnt    <= stable_next;
            phase_cnt     <= phase_next;
            o_cmd_valid   <= valid_next;
            o_cmd_type    <= type_next;
            o_cmd_slot_id <= cslot_next;
            o_slot_id     <= slot_id_next;
            o_slot_active <= active_next;
            o_ocs_cfg     <= cfg_next;
            o_slot_cnt    <= slot_cnt_next;
            o_link_err    <= err_next;
`ifdef OCS_SCHED_CMD_TIMEOUT_EN
            tmo_cnt       <= tmo_next;
`endif
        end
    end

endmodule

// File: tb/tb_ocs_slot_scheduler.sv
// Bench for ocs_slot_scheduler: randomized ready/link stimulus checked against a timeline model.
module tb_ocs_slot_scheduler;

    localparam int N    = 8;
    localparam int L    = 10;
    localparam int LEN  = 20;
    localparam int DLY  = 5;
    localparam int MAXC = 1024;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] up, rdy, valid;
    logic [1:0] ctype;
    logic       cslot, sid, act, cfg, err;
    logic [15:0] scnt;

    always #5 clk = ~clk;

    ocs_slot_scheduler #(
        .P_CHANNEL_NUM (N),
        .P_LINK_STABLE (32'd10),
        .P_SLOT_LEN    (32'd20),
        .P_CONFIG_DELAY(32'd5),
        .P_SLOT_ID_W   (1)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_channel_up (up),
        .o_cmd_valid  (valid),
        .i_cmd_ready  (rdy),
        .o_cmd_type   (ctype),
        .o_cmd_slot_id(cslot),
        .o_slot_id    (sid),
        .o_slot_active(act),
        .o_ocs_cfg    (cfg),
        .o_slot_cnt   (scnt),
        .o_link_err   (err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected timeline, indexed by cycle since reset release.
    logic [7:0]  e_valid [MAXC];
    logic [1:0]  e_type  [MAXC];
    logic        e_cslot [MAXC];
    logic        e_act   [MAXC];
    logic        e_cfg   [MAXC];
    logic        e_sid   [MAXC];
    logic [15:0] e_scnt  [MAXC];
    logic [7:0]  r_drv   [MAXC];
    int          e_len;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        up    = 8'hFF;
        rdy   = 8'($urandom);
        step;
        step;
        rst_n = 1'b1;
    endtask

    // Links up from cycle 0: START after L cycles, each command's channel k
    // gets ready d[k] cycles after valid rises; slot then cfg then next SYNC.
    task automatic build_timeline(input int ncmd, input int maxd, input bit stagger);
        int t, s, dm;
        int d[N];
        logic sm;
        logic [15:0] cm;
        for (int c = 0; c < MAXC; c++) begin
            e_valid[c] = '0; e_type[c] = '0; e_cslot[c] = 1'b0;
            e_act[c] = 1'b0; e_cfg[c] = 1'b0; e_sid[c] = 1'b0; e_scnt[c] = '0;
            r_drv[c] = 8'($urandom);
        end
        t = L; sm = 1'b0; cm = '0;
        for (int i = 0; i < ncmd; i++) begin
            dm = 0;
            for (int k = 0; k < N; k++) begin
                d[k] = stagger ? k : int'($urandom_range(0, maxd));
                if (d[k] > dm) dm = d[k];
            end
            for (int c = t; c <= t + dm + 1; c++) begin
                for (int k = 0; k < N; k++) begin
                    e_valid[c][k] = (c <= t + d[k]);
                    r_drv[c][k]   = (c >= t + d[k]);
                end
                e_type[c]  = (i == 0) ? 2'b01 : 2'b10;
                e_cslot[c] = sm;
                e_sid[c]   = sm;
                e_scnt[c]  = cm;
            end
            s = t + dm + 2;
            for (int c = s; c < s + LEN; c++) begin
                e_act[c] = 1'b1; e_sid[c] = sm; e_scnt[c] = cm;
            end
            sm = ~sm;
            cm = cm + 16'd1;
            for (int c = s + LEN; c < s + LEN + DLY; c++) begin
                e_cfg[c] = 1'b1; e_sid[c] = sm; e_scnt[c] = cm;
            end
            t = s + LEN + DLY;
        end
        e_len = t;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            up  = 8'($urandom);
            rdy = 8'($urandom);
            step;
            n_cmp++;
            if ({valid, ctype, cslot, sid, act, cfg, scnt, err} !== 31'd0) begin
                n_fail++;
                $display("FAIL reset_state i=%0d got %h required 0", i,
                         {valid, ctype, cslot, sid, act, cfg, scnt, err});
            end
        end
    endtask

    task automatic test_slot_sequence;
        logic q[$];
        for (int m = 0; m < 3; m++) begin
            case (m)
                0:       build_timeline(2, 0, 1'b0);
                1:       build_timeline(2, 0, 1'b1);
                default: build_timeline(4, 3, 1'b0);
            endcase
            q = {};
            do_reset;
            for (int c = 0; c < e_len; c++) begin
                n_cmp++;
                if ({valid, act, cfg, sid, scnt, err} !==
                    {e_valid[c], e_act[c], e_cfg[c], e_sid[c], e_scnt[c], 1'b0}) begin
                    n_fail++;
                    $display("FAIL seq%0d cyc=%0d valid/act/cfg/sid/cnt/err got %h/%b/%b/%b/%0d/%b required %h/%b/%b/%b/%0d/0",
                             m, c, valid, act, cfg, sid, scnt, err,
                             e_valid[c], e_act[c], e_cfg[c], e_sid[c], e_scnt[c]);
                end
                if (e_valid[c] != 8'h00) begin
                    n_cmp++;
                    if ({ctype, cslot} !== {e_type[c], e_cslot[c]}) begin
                        n_fail++;
                        $display("FAIL seq%0d_cmd cyc=%0d type/slot got %b/%b required %b/%b",
                                 m, c, ctype, cslot, e_type[c], e_cslot[c]);
                    end
                end
                n_cmp++;
                if ((act & cfg) !== 1'b0) begin
                    n_fail++;
                    $display("FAIL seq%0d_exclusive cyc=%0d act=%b cfg=%b required not both", m, c, act, cfg);
                end
                if (c > 0 && cfg === 1'b1 && e_cfg[c - 1] == 1'b0) q.push_back(sid);
                rdy = r_drv[c];
                step;
            end
            if (m == 2) begin
                n_cmp++;
                if (scnt !== 16'd4) begin
                    n_fail++;
                    $display("FAIL four_slots_cnt got %0d required 4", scnt);
                end
                n_cmp++;
                if (q.size() != 4) begin
                    n_fail++;
                    $display("FAIL four_slots_ids count got %0d required 4", q.size());
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        n_cmp++;
                        if (q[i] !== ((i % 2) == 0)) begin
                            n_fail++;
                            $display("FAIL four_slots_id%0d got %b required %b", i, q[i], ((i % 2) == 0));
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_link_glitch;
        int g, w, ch;
        logic [7:0] mask;
        for (int n = 0; n < 3; n++) begin
            if (n == 0) begin g = 8; w = 1; ch = 3; end
            else begin
                g  = int'($urandom_range(0, 9));
                w  = int'($urandom_range(1, 3));
                ch = int'($urandom_range(0, 7));
            end
            mask = 8'h01 << ch;
            do_reset;
            rdy = 8'hFF;
            for (int c = 0; c < g + w + L; c++) begin
                up = (c >= g && c < g + w) ? ~mask : 8'hFF;
                step;
                n_cmp++;
                if (err !== 1'b0 || valid !== ((c + 1 == g + w + L) ? 8'hFF : 8'h00)) begin
                    n_fail++;
                    $display("FAIL glitch%0d cyc=%0d err/valid got %b/%h required 0/%h", n, c + 1, err, valid,
                             (c + 1 == g + w + L) ? 8'hFF : 8'h00);
                end
            end
        end
    endtask

    task automatic test_link_loss;
        int drops[5] = '{51, 58, 63, 64, 0};
        int drop, ch, h, ecnt;
        for (int n = 0; n < 5; n++) begin
            drop = (n == 4) ? int'($urandom_range(10, 75)) : drops[n];
            ch   = (n == 4) ? int'($urandom_range(0, 7)) : 5;
            ecnt = 0;
            for (int k = 0; k < 4; k++) if (12 + 27 * k + LEN <= drop) ecnt++;
            do_reset;
            rdy = 8'hFF;
            for (int c = 0; c < drop; c++) step;
            n_cmp++;
            if (scnt !== 16'(ecnt)) begin
                n_fail++;
                $display("FAIL loss%0d_precnt cyc=%0d got %0d required %0d", n, drop, scnt, ecnt);
            end
            up[ch] = 1'b0;
            step;
            n_cmp++;
            if ({err, valid, act, cfg, sid, scnt} !== {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'(ecnt)}) begin
                n_fail++;
                $display("FAIL loss%0d_drop cyc=%0d err/valid/act/cfg/sid/cnt got %b/%h/%b/%b/%b/%0d required 1/00/0/0/0/%0d",
                         n, drop + 1, err, valid, act, cfg, sid, scnt, ecnt);
            end
            h = int'($urandom_range(1, 3));
            for (int j = 0; j < h; j++) begin
                rdy = 8'($urandom);
                step;
                n_cmp++;
                if ({err, valid, act} !== 10'd0) begin
                    n_fail++;
                    $display("FAIL loss%0d_hold j=%0d err/valid/act got %b/%h/%b required 0/00/0", n, j, err, valid, act);
                end
            end
            up  = 8'hFF;
            rdy = 8'hFF;
            for (int j = 0; j < L - 1; j++) begin
                step;
                n_cmp++;
                if ({err, valid} !== 9'd0) begin
                    n_fail++;
                    $display("FAIL loss%0d_wait j=%0d err/valid got %b/%h required 0/00", n, j, err, valid);
                end
            end
            step;
            n_cmp++;
            if ({valid, ctype, cslot, sid, scnt} !== {8'hFF, 2'b01, 1'b0, 1'b0, 16'(ecnt)}) begin
                n_fail++;
                $display("FAIL loss%0d_restart valid/type/cslot/sid/cnt got %h/%b/%b/%b/%0d required ff/01/0/0/%0d",
                         n, valid, ctype, cslot, sid, scnt, ecnt);
            end
        end
    endtask

    task automatic test_midop_reset;
        do_reset;
        rdy = 8'h00;
        repeat (15) step;
        n_cmp++;
        if (valid !== 8'hFF) begin
            n_fail++;
            $display("FAIL midrst_pending got %h required ff", valid);
        end
        rst_n = 1'b0;
        step;
        n_cmp++;
        if ({valid, ctype, cslot, sid, act, cfg, scnt, err} !== 31'd0) begin
            n_fail++;
            $display("FAIL midrst_cmd got %h required 0", {valid, ctype, cslot, sid, act, cfg, scnt, err});
        end
        do_reset;
        rdy = 8'hFF;
        repeat (70) step;
        n_cmp++;
        if ({act, scnt} !== {1'b1, 16'd2}) begin
            n_fail++;
            $display("FAIL midrst_slot_pre act/cnt got %b/%0d required 1/2", act, scnt);
        end
        rst_n = 1'b0;
        rdy   = 8'($urandom);
        step;
        n_cmp++;
        if ({valid, ctype, cslot, sid, act, cfg, scnt, err} !== 31'd0) begin
            n_fail++;
            $display("FAIL midrst_slot got %h required 0", {valid, ctype, cslot, sid, act, cfg, scnt, err});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_cmd_timeout;
        int t_err, bad;
        logic [7:0] v_err, v_re;
        do_reset;
        rdy = 8'hFF;
        repeat (37) step;
        n_cmp++;
        if ({valid, ctype, cslot} !== {8'hFF, 2'b10, 1'b1}) begin
            n_fail++;
            $display("FAIL tmo_sync valid/type/cslot got %h/%b/%b required ff/10/1", valid, ctype, cslot);
        end
        rdy   = 8'hFB;
        t_err = -1; bad = 0; v_err = 8'hXX; v_re = 8'hXX;
        for (int c = 38; c <= 4200; c++) begin
            step;
            if (err === 1'b1 && t_err < 0) begin t_err = c; v_err = valid; end
            if (t_err >= 0 && c == t_err + L) v_re = valid;
            if (t_err < 0 && valid !== 8'h04) bad++;
        end
`ifdef OCS_SCHED_CMD_TIMEOUT_EN
        n_cmp++;
        if (t_err != 37 + 4096) begin
            n_fail++;
            $display("FAIL tmo_cycle got %0d required %0d", t_err, 37 + 4096);
        end
        n_cmp++;
        if ({v_err, v_re} !== {8'h00, 8'hFF}) begin
            n_fail++;
            $display("FAIL tmo_abort valid_at_err/valid_restart got %h/%h required 00/ff", v_err, v_re);
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL tmo_wait bad_cycles got %0d required 0", bad);
        end
`else
        n_cmp++;
        if (t_err != -1) begin
            n_fail++;
            $display("FAIL notmo_err got err at %0d required none", t_err);
        end
        n_cmp++;
        if (bad != 0 || valid !== 8'h04) begin
            n_fail++;
            $display("FAIL notmo_hold bad_cycles/valid got %0d/%h required 0/04", bad, valid);
        end
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        up    = 8'hFF;
        rdy   = 8'h00;
        test_reset;
        test_slot_sequence;
        test_link_glitch;
        test_link_loss;
        test_midop_reset;
        test_cmd_timeout;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
